// File: rtl/multicycle_control.sv
// Multi-cycle Beta control sequencer on a shared, variable-latency memory port.
// Optional bus-timeout fault: define MCTRL_MEM_TIMEOUT_EN.
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic [5:0] op_code,
    input  logic       Z,
    input  logic       IRQ,
    input  logic       supervisor,
    input  logic       mem_ready,
    output logic [5:0] ALUFN,
    output logic       ASEL,
    output logic       BSEL,
    output logic       RA2SEL,
    output logic       WASEL,
    output logic [1:0] WDSEL,
    output logic [2:0] PCSEL,
    output logic       MOE,
    output logic       MWR,
    output logic       MEM_REQ,
    output logic       IR_LD,
    output logic       PC_LD,
    output logic       WERF,
    output logic [2:0] state,
    output logic       bus_fault
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_IRQ    = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam logic [2:0] S_FAULT  = 3'd6;
    localparam logic [2:0] S_RST    = 3'd7;

    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LD  = 6'h18;
    localparam logic [5:0] OP_ST  = 6'h19;
    localparam logic [5:0] OP_JMP = 6'h1B;
    localparam logic [5:0] OP_BEQ = 6'h1C;
    localparam logic [5:0] OP_BNE = 6'h1D;
    localparam logic [5:0] OP_LDR = 6'h1F;

    localparam logic [5:0] AFN_DEF = 6'b101010;
    localparam logic [5:0] AFN_ADD = 6'b010000;

    logic [2:0] state_q;
    logic [2:0] next_state;
    logic       nib_ok;
    logic       alu_r;
    logic       alu_c;
    logic       is_mem;
    logic       legal;
    logic       timeout;
    logic [5:0] alu_fn;

    assign state = state_q;

    // Low nibble picks the ALU op; register and constant forms share it.
    always_comb begin
        alu_fn = AFN_DEF;
        nib_ok = 1'b1;
        unique case (op_code[3:0])
            4'h0: alu_fn = 6'b010000;
            4'h1: alu_fn = 6'b010001;
            4'h4: alu_fn = 6'b000011;
            4'h5: alu_fn = 6'b000101;
            4'h6: alu_fn = 6'b000111;
            4'h8: alu_fn = 6'b101000;
            4'h9: alu_fn = 6'b101110;
            4'hA: alu_fn = 6'b100110;
            4'hB: alu_fn = 6'b101001;
            4'hC: alu_fn = 6'b110000;
            4'hD: alu_fn = 6'b110001;
            4'hE: alu_fn = 6'b110011;
            default: nib_ok = 1'b0;
        endcase
    end

    assign alu_r  = nib_ok && (op_code[5:4] == 2'b10);
    assign alu_c  = nib_ok && (op_code[5:4] == 2'b11);
    assign is_mem = (op_code == OP_LD) || (op_code == OP_ST)
                 || (op_code == OP_LDR);
    assign legal  = alu_r || alu_c || is_mem
                 || (op_code == OP_NOP) || (op_code == OP_JMP)
                 || (op_code == OP_BEQ) || (op_code == OP_BNE);

`ifdef MCTRL_MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;

    // Counts consecutive not-ready cycles; cleared whenever a wait ends.
    always_ff @(posedge clk) begin
        if (RESET) begin
            wait_cnt <= 8'd0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    assign timeout   = !mem_ready && (wait_cnt >= 8'(TIMEOUT_CYCLES - 1));
    assign bus_fault = (state_q == S_FAULT);
`else
    assign timeout   = 1'b0;
    assign bus_fault = 1'b0;
`endif

    always_comb begin
        next_state = S_RST;
        unique case (state_q)
            S_RST:   next_state = S_FETCH;
            S_FETCH, S_MEM: begin
                if (mem_ready)    next_state = (state_q == S_FETCH) ? S_DECODE : S_FETCH;
                else if (timeout) next_state = S_FAULT;
                else              next_state = state_q;
            end
            S_DECODE: begin
                if (IRQ && !supervisor) next_state = S_IRQ;
                else if (!legal)        next_state = S_TRAP;
                else if (is_mem)        next_state = S_MEM;
                else                    next_state = S_EXEC;
            end
            default: next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) state_q <= S_RST;
        else       state_q <= next_state;
    end

    always_comb begin
        ALUFN   = AFN_DEF;
        ASEL    = 1'b0;
        BSEL    = 1'b0;
        RA2SEL  = 1'b0;
        WASEL   = 1'b0;
        WDSEL   = 2'b00;
        PCSEL   = 3'b000;
        MOE     = 1'b0;
        MWR     = 1'b0;
        MEM_REQ = 1'b0;
        IR_LD   = 1'b0;
        PC_LD   = 1'b0;
        WERF    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MEM_REQ = 1'b1;
                MOE     = 1'b1;
                IR_LD   = mem_ready;
            end
            S_EXEC: begin
                PC_LD = 1'b1;
                if (alu_r || alu_c) begin
                    WERF  = 1'b1;
                    WDSEL = 2'b01;
                    BSEL  = alu_c;
                    ALUFN = alu_fn;
                end else if (op_code == OP_JMP) begin
                    WERF  = 1'b1;
                    PCSEL = 3'b010;
                end else if (op_code == OP_BEQ) begin
                    WERF  = 1'b1;
                    PCSEL = Z ? 3'b001 : 3'b000;
                end else if (op_code == OP_BNE) begin
                    WERF  = 1'b1;
                    PCSEL = Z ? 3'b000 : 3'b001;
                end
            end
            S_MEM: begin
                MEM_REQ = 1'b1;
                if (op_code == OP_LDR) begin
                    ASEL = 1'b1;
                end else begin
                    ALUFN = AFN_ADD;
                    BSEL  = 1'b1;
                end
                if (op_code == OP_ST) begin
                    MWR    = 1'b1;
                    RA2SEL = 1'b1;
                end else begin
                    MOE = 1'b1;
                end
                if (mem_ready) begin
                    PC_LD = 1'b1;
                    if (op_code != OP_ST) begin
                        WERF  = 1'b1;
                        WDSEL = 2'b10;
                    end
                end
            end
            S_IRQ, S_TRAP, S_FAULT: begin
                WASEL = 1'b1;
                WERF  = 1'b1;
                PC_LD = 1'b1;
                PCSEL = (state_q == S_IRQ)  ? 3'b100 :
                        (state_q == S_TRAP) ? 3'b011 : 3'b101;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control words
// are queued as stimulus is driven and checked at the falling edge.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] st;
        logic [5:0] alufn;
        logic       asel;
        logic       bsel;
        logic       ra2sel;
        logic       wasel;
        logic [1:0] wdsel;
        logic [2:0] pcsel;
        logic       moe;
        logic       mwr;
        logic       mem_req;
        logic       ir_ld;
        logic       pc_ld;
        logic       werf;
        logic       bf;
    } mc_t;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic [5:0] op_code = 6'h20;
    logic       Z = 1'b0;
    logic       IRQ = 1'b0;
    logic       supervisor = 1'b0;
    logic       mem_ready = 1'b1;
    logic [5:0] ALUFN;
    logic       ASEL, BSEL, RA2SEL, WASEL;
    logic [1:0] WDSEL;
    logic [2:0] PCSEL;
    logic       MOE, MWR, MEM_REQ, IR_LD, PC_LD, WERF;
    logic [2:0] state;
    logic       bus_fault;

    mc_t obs;
    mc_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    multicycle_control #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .RESET(RESET), .op_code(op_code), .Z(Z), .IRQ(IRQ),
        .supervisor(supervisor), .mem_ready(mem_ready), .ALUFN(ALUFN),
        .ASEL(ASEL), .BSEL(BSEL), .RA2SEL(RA2SEL), .WASEL(WASEL),
        .WDSEL(WDSEL), .PCSEL(PCSEL), .MOE(MOE), .MWR(MWR),
        .MEM_REQ(MEM_REQ), .IR_LD(IR_LD), .PC_LD(PC_LD), .WERF(WERF),
        .state(state), .bus_fault(bus_fault)
    );

    always #5 clk = ~clk;

    assign obs = '{state, ALUFN, ASEL, BSEL, RA2SEL, WASEL, WDSEL, PCSEL,
                   MOE, MWR, MEM_REQ, IR_LD, PC_LD, WERF, bus_fault};

    function automatic mc_t base(input logic [2:0] s);
        mc_t e = '0;
        e.st    = s;
        e.alufn = 6'b101010;
        return e;
    endfunction

    function automatic mc_t fetch_e(input logic rdy);
        mc_t e = base(3'd0);
        e.mem_req = 1'b1;
        e.moe     = 1'b1;
        e.ir_ld   = rdy;
        return e;
    endfunction

    function automatic mc_t exec_e(input logic [5:0] fn, input logic b,
                                   input logic w, input logic [1:0] wd,
                                   input logic [2:0] pc);
        mc_t e = base(3'd2);
        e.alufn = fn;
        e.bsel  = b;
        e.werf  = w;
        e.wdsel = wd;
        e.pcsel = pc;
        e.pc_ld = 1'b1;
        return e;
    endfunction

    function automatic mc_t mem_e(input logic ldr, input logic st,
                                  input logic rdy);
        mc_t e = base(3'd3);
        e.mem_req = 1'b1;
        e.alufn   = ldr ? 6'b101010 : 6'b010000;
        e.asel    = ldr;
        e.bsel    = !ldr;
        e.mwr     = st;
        e.ra2sel  = st;
        e.moe     = !st;
        e.pc_ld   = rdy;
        e.werf    = rdy && !st;
        e.wdsel   = (rdy && !st) ? 2'b10 : 2'b00;
        return e;
    endfunction

    function automatic mc_t vec_e(input logic [2:0] s, input logic [2:0] pc);
        mc_t e = base(s);
        e.pcsel = pc;
        e.wasel = 1'b1;
        e.werf  = 1'b1;
        e.pc_ld = 1'b1;
        e.bf    = (s == 3'd6);
        return e;
    endfunction

    task automatic cyc(input string tag, input mc_t e);
        mc_t x;
        sb.push_back(e);
        @(negedge clk);
        x = sb.pop_front();
        vectors++;
        assert (obs === x) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset", base(3'd7));
        RESET = 1'b0;
        cyc("rst_exit", base(3'd7));
        cyc("add_fetch", fetch_e(1'b1));
        cyc("add_decode", base(3'd1));
        cyc("add_exec", exec_e(6'b010000, 1'b0, 1'b1, 2'b01, 3'b000));

        op_code = 6'h18;
        cyc("ld_fetch", fetch_e(1'b1));
        cyc("ld_decode", base(3'd1));
        mem_ready = 1'b0;
        cyc("ld_mem_w0", mem_e(1'b0, 1'b0, 1'b0));
        cyc("ld_mem_w1", mem_e(1'b0, 1'b0, 1'b0));
        mem_ready = 1'b1;
        cyc("ld_mem_done", mem_e(1'b0, 1'b0, 1'b1));

        op_code = 6'h1D;
        cyc("bne_fetch", fetch_e(1'b1));
        cyc("bne_decode", base(3'd1));
        cyc("bne_z0", exec_e(6'b101010, 1'b0, 1'b1, 2'b00, 3'b001));
        cyc("bne2_fetch", fetch_e(1'b1));
        cyc("bne2_decode", base(3'd1));
        Z = 1'b1;
        cyc("bne_z1", exec_e(6'b101010, 1'b0, 1'b1, 2'b00, 3'b000));
        Z = 1'b0;

        op_code = 6'h3A;
        cyc("xorc_fetch", fetch_e(1'b1));
        cyc("xorc_decode", base(3'd1));
        cyc("xorc_exec", exec_e(6'b100110, 1'b1, 1'b1, 2'b01, 3'b000));

        op_code = 6'h3F;
        IRQ = 1'b1;
        cyc("irq_fetch", fetch_e(1'b1));
        cyc("irq_decode", base(3'd1));
        cyc("irq_state", vec_e(3'd4, 3'b100));
        IRQ = 1'b0;
        cyc("trap_fetch", fetch_e(1'b1));
        cyc("trap_decode", base(3'd1));
        cyc("trap_state", vec_e(3'd5, 3'b011));

        op_code = 6'h00;
        IRQ = 1'b1;
        supervisor = 1'b1;
        cyc("nop_fetch", fetch_e(1'b1));
        cyc("nop_decode", base(3'd1));
        cyc("nop_exec", exec_e(6'b101010, 1'b0, 1'b0, 2'b00, 3'b000));
        IRQ = 1'b0;
        supervisor = 1'b0;

        op_code = 6'h1F;
        cyc("ldr_fetch", fetch_e(1'b1));
        cyc("ldr_decode", base(3'd1));
        cyc("ldr_mem", mem_e(1'b1, 1'b0, 1'b1));

        op_code = 6'h19;
        cyc("st_fetch", fetch_e(1'b1));
        cyc("st_decode", base(3'd1));
        mem_ready = 1'b0;
        cyc("st_mem_w0", mem_e(1'b0, 1'b1, 1'b0));
        RESET = 1'b1;
        cyc("st_mem_rst", mem_e(1'b0, 1'b1, 1'b0));
        RESET = 1'b0;
        cyc("st_abandon", base(3'd7));
        mem_ready = 1'b1;
        op_code = 6'h1B;
        cyc("jmp_fetch", fetch_e(1'b1));
        cyc("jmp_decode", base(3'd1));
        cyc("jmp_exec", exec_e(6'b101010, 1'b0, 1'b1, 2'b00, 3'b010));

        mem_ready = 1'b0;
`ifdef MCTRL_MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", fetch_e(1'b0));
        cyc("to_fault", vec_e(3'd6, 3'b101));
        mem_ready = 1'b1;
        cyc("to_refetch", fetch_e(1'b1));
        op_code = 6'h20;
        cyc("to_decode", base(3'd1));
        cyc("to_exec", exec_e(6'b010000, 1'b0, 1'b1, 2'b01, 3'b000));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("rw_fetch_wait", fetch_e(1'b0));
        mem_ready = 1'b1;
        cyc("rw_fetch_ready", fetch_e(1'b1));
        cyc("rw_decode", base(3'd1));
`else
        for (int i = 0; i < 20; i++) cyc("nto_fetch_wait", fetch_e(1'b0));
        mem_ready = 1'b1;
        cyc("nto_fetch_ready", fetch_e(1'b1));
        cyc("nto_decode", base(3'd1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control sequencer for the Beta-style datapath. It replaces single-cycle combinational decode with a state machine that runs fetch, decode, execute and memory phases, and waits on a `mem_ready` handshake so the core can use a single shared, variable-latency memory port. It also takes interrupts, illegal-opcode traps and (optionally) bus-timeout faults at defined instruction boundaries.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: number of consecutive cycles with `mem_ready` low before a bus fault is raised. Legal range is 1..255.

Ports:
- `clk`  in  1  rising-edge clock
- `RESET`  in  1  reset, synchronous, active-high
- `op_code`  in  6  opcode field of the instruction register; valid from DECODE onward
- `Z`  in  1  Ra==0 flag from the register file
- `IRQ`  in  1  level interrupt request
- `supervisor`  in  1  PC[31]; when 1, `IRQ` is ignored
- `mem_ready`  in  1  memory completes the current access this cycle
- `ALUFN`  out  6  ALU function
- `ASEL`, `BSEL`, `RA2SEL`, `WASEL`  out  1 each  datapath mux selects
- `WDSEL`  out  2  write-data select: 00 = PC+4, 01 = ALU, 10 = memory
- `PCSEL`  out  3  next-PC select: 000 = +4, 001 = branch, 010 = JMP, 011 = ILLOP, 100 = XADR, 101 = bus-fault vector
- `MOE`, `MWR`, `MEM_REQ`  out  1 each  memory output enable, write, request
- `IR_LD`  out  1  load the instruction register
- `PC_LD`  out  1  commit the next PC
- `WERF`  out  1  register-file write enable
- `state`  out  3  current state, for debug
- `bus_fault`  out  1  one-cycle pulse on entry to FAULT

## Operation
- All outputs decode combinationally from `state` and `op_code` (plus `Z` in EXEC).
- Outputs not listed for a state are 0, except `ALUFN`, which defaults to AFN = 6'b101010.
- `WERF` and `PC_LD` are asserted only in a commit cycle, so every instruction writes the PC and the register file at most once.

States, with their `state` encoding, outputs and transitions:
- RST (7): all outputs inactive. Moves to FETCH on the first cycle with `RESET` low.
- FETCH (0): `MEM_REQ`=1, `MOE`=1.
  - `mem_ready`=1: `IR_LD`=1, go to DECODE.
  - `mem_ready`=0: stay in FETCH.
- DECODE (1): no outputs. Transitions in priority order:
  - `IRQ` & ~`supervisor` → IRQ.
  - Opcode not in the legal set → TRAP.
  - LD (0x18), ST (0x19), LDR (0x1F) → MEM.
  - Otherwise → EXEC.
- EXEC (2): `PC_LD`=1, then go to FETCH.
  - ALU register ops (0x20, 21, 24, 25, 26, 28, 29, 2A, 2B, 2C, 2D, 2E): `WERF`=1, `WDSEL`=01, `BSEL`=0.
  - The matching constant forms (opcode + 0x10): same, with `BSEL`=1.
  - ALUFN: ADD 010000, SUB 010001, CMPEQ 000011, CMPLT 000101, CMPLE 000111, AND 101000, OR 101110, XOR 100110, XNOR 101001, SHL 110000, SHR 110001, SRA 110011.
  - NOP (0x00): `PC_LD` only.
  - JMP: `PCSEL`=010, `WERF`=1, `WDSEL`=00.
  - BEQ: `PCSEL` = `Z` ? 001 : 000. BNE: `PCSEL` = `Z` ? 000 : 001. Both assert `WERF`=1, `WDSEL`=00.
- MEM (3): `MEM_REQ`=1, `ALUFN`=ADD, `BSEL`=1. LDR instead uses `ASEL`=1, `BSEL`=0, `ALUFN`=AFN.
  - LD/LDR: `MOE`=1. ST: `MWR`=1, `RA2SEL`=1.
  - While `mem_ready`=0: no commit, stay in MEM.
  - On `mem_ready`=1: `PC_LD`=1. LD/LDR also assert `WERF`=1, `WDSEL`=10. Then go to FETCH.
- IRQ (4): `PCSEL`=100, `WASEL`=1, `WDSEL`=00, `WERF`=1, `PC_LD`=1. The fetched instruction is discarded and XP receives PC+4. Then go to FETCH.
- TRAP (5): as IRQ, but `PCSEL`=011.
- FAULT (6): as IRQ, but `PCSEL`=101 and `bus_fault`=1. Then go to FETCH.

Boundary rules:
- `RESET`=1 in any state forces RST on the next edge. An in-flight access is abandoned with no register or PC write.
- `IRQ` is sampled only in DECODE. An `IRQ` that rises during FETCH or MEM waits for the next DECODE.
- `IRQ` and an illegal opcode in the same DECODE: IRQ wins.

## Timing
- After `RESET` deasserts: RST for 1 cycle, then FETCH.
- With zero wait states: ALU/branch/JMP/NOP take 3 cycles (FETCH, DECODE, EXEC); LD/ST/LDR take 3 cycles (FETCH, DECODE, MEM).
- Each cycle with `mem_ready` low adds 1 cycle.
- IRQ, TRAP and FAULT each occupy exactly 1 cycle.
- Wait counter (8 bit):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle `mem_ready` is low in those states.
  - Saturates; never wraps.

## Configuration
- `MCTRL_MEM_TIMEOUT_EN` defined:
  - When the wait counter reaches `TIMEOUT_CYCLES` with `mem_ready` still low, the next state is FAULT.
  - `MEM_REQ` drops in the FAULT cycle.
  - `mem_ready` arriving in the same cycle as the threshold completes the access normally (ready wins).
- `MCTRL_MEM_TIMEOUT_EN` undefined:
  - FETCH and MEM wait indefinitely.
  - FAULT is unreachable and `bus_fault` is tied to 0.
  - The wait counter is removed.

## Test plan
- Reset, then ADD (0x20) with `mem_ready` held 1 → `state` sequence 7,0,1,2. In EXEC: `WERF`=1, `WDSEL`=01, `ALUFN`=010000, `PC_LD`=1.
- LD (0x18) with `mem_ready` low for 2 cycles in MEM → MEM lasts 3 cycles. `WERF`=1 and `WDSEL`=10 only in the final cycle.
- BNE with `Z`=0 → `PCSEL`=001. BNE with `Z`=1 → `PCSEL`=000. `WERF`=1 in both cases.
- Opcode 0x3F with `IRQ`=1 and `supervisor`=0 → IRQ state, `PCSEL`=100. The same with `IRQ`=0 → TRAP, `PCSEL`=011, `WASEL`=1.
- Macro defined, `TIMEOUT_CYCLES`=4, FETCH with `mem_ready` stuck at 0 → FAULT after 4 wait cycles, with a 1-cycle `bus_fault` pulse and `PCSEL`=101.
- `RESET` pulsed mid-MEM for a ST → next state RST. `MWR`, `WERF` and `PC_LD` stay 0 from that edge onward.
